// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a shared 4:1 mux channel. Drives the registered selects and
// gates the owner's data bit onto Y. A hold limit stops any single requester from starving the rest.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] D,
    output logic [3:0] grant,
    output logic       S1,
    output logic       S0,
    output logic       Y,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      pick;

    // First requester found scanning last+1 .. last+4, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req, last_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = 4'b0001 << pick;
                    sel_d   = pick;
                    cnt_d   = CW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release always passes through IDLE, so a handover costs one dead cycle.
                if (!req[sel_q] || (cnt_q == CW'(MAX_HOLD))) begin
                    grant_d = 4'b0000;
                    last_d  = sel_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign S1    = sel_q[1];
    assign S0    = sel_q[0];
    assign busy  = (state_q == GRANT);
    assign Y     = (|grant_q) ? D[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: hand-computed grant/select/Y/busy expectations
// checked with immediate assertions one microsecond-free step at a time.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] D;
    logic [3:0] grant;
    logic       S1;
    logic       S0;
    logic       Y;
    logic       busy;

    int vectors;
    int miscompares;
    logic [3:0] dpat;

    rr_mux_arbiter #(.MAX_HOLD(4), .CW(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .D    (D),
        .grant(grant),
        .S1   (S1),
        .S0   (S0),
        .Y    (Y),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                       input logic ey, input logic eb);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {grant, S1, S0, Y, busy};
        exp = {eg, es, ey, eb};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed grant,S1S0,Y,busy=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        req = 4'b0000;
        D   = 4'b0000;

        // Reset state and an idle channel
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        D   = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_noreq", 4'b0000, 2'b00, 1'b0, 1'b0);
        end

        // Single requester 0, drop after two granted cycles
        req = 4'b0001;
        D   = 4'b0001;
        step();
        chk("t1_grant_c1", 4'b0001, 2'b00, 1'b1, 1'b1);
        step();
        chk("t1_grant_c2", 4'b0001, 2'b00, 1'b1, 1'b1);
        req = 4'b0000;
        step();
        chk("t1_release", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Fresh reset so requester 0 is first again, then full rotation
        #2 rst = 1'b1;
        #1;
        chk("rst_pulse", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst  = 1'b0;
        req  = 4'b1111;
        dpat = 4'b1010;
        D    = dpat;
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk("rot_grant", 4'b0001 << o, o[1:0], dpat[o], 1'b1);
            end
            step();
            chk("rot_gap", 4'b0000, o[1:0], 1'b0, 1'b0);
        end
        step();
        chk("rot_wrap", 4'b0001, 2'b00, 1'b0, 1'b1);

        // Lone requester 2: forced release and re-grant, Y tracks only D[2]
        req = 4'b0100;
        D   = 4'b0100;
        step();
        chk("t3_release0", 4'b0000, 2'b00, 1'b0, 1'b0);
        step();
        chk("t3_c1", 4'b0100, 2'b10, 1'b1, 1'b1);
        D = 4'b1011;
        step();
        chk("t3_c2", 4'b0100, 2'b10, 1'b0, 1'b1);
        D = 4'b1111;
        step();
        chk("t3_c3", 4'b0100, 2'b10, 1'b1, 1'b1);
        D = 4'b0000;
        step();
        chk("t3_c4", 4'b0100, 2'b10, 1'b0, 1'b1);
        D = 4'b0100;
        #1;
        chk("t3_comb_y", 4'b0100, 2'b10, 1'b1, 1'b1);
        step();
        chk("t3_hold_gap", 4'b0000, 2'b10, 1'b0, 1'b0);
        step();
        chk("t3_regrant", 4'b0100, 2'b10, 1'b1, 1'b1);

        // Owner 1 is not preempted; requester 3 wins after last=1
        req = 4'b0010;
        step();
        chk("t4_rel2", 4'b0000, 2'b10, 1'b0, 1'b0);
        D = 4'b0010;
        step();
        chk("t4_own1", 4'b0010, 2'b01, 1'b1, 1'b1);
        req = 4'b1011;
        step();
        chk("t4_nopre_a", 4'b0010, 2'b01, 1'b1, 1'b1);
        step();
        chk("t4_nopre_b", 4'b0010, 2'b01, 1'b1, 1'b1);
        req = 4'b1001;
        D   = 4'b1000;
        step();
        chk("t4_gap", 4'b0000, 2'b01, 1'b0, 1'b0);
        step();
        chk("t4_own3", 4'b1000, 2'b11, 1'b1, 1'b1);

        // Asynchronous reset mid-grant with owner 1 at cnt=2
        req = 4'b0010;
        D   = 4'b0000;
        step();
        chk("t5_rel3", 4'b0000, 2'b11, 1'b0, 1'b0);
        step();
        chk("t5_own1_c1", 4'b0010, 2'b01, 1'b0, 1'b1);
        D = 4'b0010;
        step();
        chk("t5_own1_c2", 4'b0010, 2'b01, 1'b1, 1'b1);
        D = 4'b1111;
        #2 rst = 1'b1;
        #1;
        chk("t5_async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
        req = 4'b1010;
        D   = 4'b1010;
        step();
        chk("t5_rst_held", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk("t5_first", 4'b0010, 2'b01, 1'b1, 1'b1);

        // req drop coinciding with the hold limit gives a single release
        step();
        chk("t6_c2", 4'b0010, 2'b01, 1'b1, 1'b1);
        step();
        chk("t6_c3", 4'b0010, 2'b01, 1'b1, 1'b1);
        step();
        chk("t6_c4", 4'b0010, 2'b01, 1'b1, 1'b1);
        req = 4'b1000;
        step();
        chk("t6_release", 4'b0000, 2'b01, 1'b0, 1'b0);
        step();
        chk("t6_own3", 4'b1000, 2'b11, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin scheduler that shares one 4:1 multiplexed channel between four requesters.
- Decides which requester owns the channel and drives the mux select lines S1/S0.
- Gates the selected data bit onto Y.
- Enforces a maximum hold time so no requester can starve the others.
- Sits between the four requesting sources and the shared 4:1 mux datapath, and fully controls the mux selects.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may hold the grant. Legal range 1..7.
- CW, 3: hold-counter width. Must satisfy 2^CW-1 >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i]=1 means requester i wants the channel.
- D  input  4  data bits; D[i] belongs to requester i.
- grant  output  4  one-hot grant, registered; all zero when idle.
- S1  output  1  mux select MSB, registered; owner index bit 1.
- S0  output  1  mux select LSB, registered; owner index bit 0.
- Y  output  1  channel output: D[{S1,S0}] when any grant bit is set, else 0 (combinational).
- busy  output  1  1 while in state GRANT.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, grant=0000, S1=0, S0=0, busy=0, Y=0, hold count cnt=0, last-owner pointer last=3.
  - With last=3, requester 0 has top priority after reset.
  - Reset asserted mid-grant clears everything immediately, without waiting for a clock.
- State IDLE:
  - At each rising edge, if req != 0, pick the first i with req[i]=1, scanning last+1, last+2, last+3, last+4 (mod 4).
  - At that edge: grant <= onehot(i), {S1,S0} <= i, cnt <= 1, state <= GRANT.
  - If req == 0: stay in IDLE; S1/S0 hold their previous value.
- State GRANT, owner o:
  - At each rising edge, release if req[o]==0 or cnt==MAX_HOLD.
  - On release: grant <= 0000, last <= o, state <= IDLE, cnt <= 0. S1/S0 keep o.
  - Otherwise: cnt <= cnt+1, grant unchanged.
- Latency:
  - Request sampled in IDLE becomes a grant at the same edge, so grant is visible 1 cycle after req is seen high.
  - Every ownership change passes through exactly one IDLE cycle (dead cycle, grant=0, Y=0). There is never a direct owner-to-owner handover.
- Hold limit: a requester holding req high is granted for exactly MAX_HOLD consecutive cycles, then forcibly released.
- After a forced release the owner has lowest priority.
  - If it is the only requester, it is re-granted after the one-cycle gap.
- Requests from non-owners while in GRANT are ignored until the next IDLE edge; no preemption.
- req deasserting in the same cycle the hold limit is reached gives a single release; behaviour is identical to either cause alone.
- Y follows D[owner] combinationally within the grant window. D changes of non-owners never affect Y.
- grant is always one-hot or zero, and {S1,S0} always equals the index of the set grant bit whenever grant != 0.

Test Plan:
- Reset then req=0001, D=0001 held -> grant=0001 one cycle later, S1S0=00, Y=1, busy=1.
  - Drop req after 2 granted cycles -> grant=0000 at the next edge, busy=0.
- req=1111 held continuously, MAX_HOLD=4 -> grants rotate 0001,0010,0100,1000,0001.
  - Each grant lasts 4 cycles, followed by 1 idle cycle; S1S0 sequence is 00,01,10,11,00.
- Only req[2]=1 held -> grant=0100 for 4 cycles, 1 cycle of 0000, then 0100 again. Y tracks D[2] toggling; D[0]/D[1]/D[3] toggling has no effect on Y.
- Owner 1 granted; assert req[0] and req[3] mid-grant -> no preemption.
  - After owner 1 releases, next grant is 1000 (index 3 comes before 0 after last=1).
- Assert rst asynchronously while grant=0010 and cnt=2 -> grant=0000, S1S0=00, busy=0, Y=0 immediately.
  - After rst falls with req=1010 -> first grant is 0010.
- req=0000 for 10 cycles after reset -> grant stays 0000, Y stays 0, S1S0 stays 00, busy stays 0.
